// File: rtl/lookup_node_feeder.sv
// lookup_node_feeder
//   Streams clause nodes out of the host-loaded node RAM into the lookup
//   engine's node_in/node_in_valid port, inserting a one-cycle change_eng
//   pulse at every engine-segment boundary. Honours halt back-pressure and
//   aborts the whole transfer on conflict.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             launch pulse (IDLE only); latches base_addr, num_eng
//   mem_rd_en/addr    read strobe and address to node RAM
//   mem_rdata         {last, node}, valid one cycle after mem_rd_en
//   node_in/_valid    node beat to the engine; transfers when valid && !halt
//   halt              engine stall
//   change_eng        engine-switch pulse (one cycle per segment boundary)
//   conflict          abort request from the engine
//   busy, done        not-IDLE flag, one-cycle completion pulse
//   aborted           sticky abort flag, cleared by the next start
//   perf_nodes/stalls transferred beats / stalled cycles
//
// Optional feature: define LOOKUP_FEEDER_PERF_EN to build the saturating
// perf counters; otherwise perf_nodes/perf_stalls are constant 0.
module lookup_node_feeder #(
  parameter int NODE_W = 32,
  parameter int ADDR_W = 12,
  parameter int ENG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ENG_W-1:0]  num_eng,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [NODE_W:0]   mem_rdata,
  output logic [NODE_W-1:0] node_in,
  output logic              node_in_valid,
  input  logic              halt,
  output logic              change_eng,
  input  logic              conflict,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [31:0]       perf_nodes,
  output logic [31:0]       perf_stalls
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ENG_W-1:0]  num_eng_q, num_eng_d;
  logic [ENG_W-1:0]  fetch_eng_q, fetch_eng_d;
  logic [ENG_W-1:0]  send_eng_q, send_eng_d;
  logic              rvalid_q, rvalid_d;
  logic              aborted_q, aborted_d;

  // Two-entry prefetch FIFO
  logic [NODE_W-1:0] fifo_data_q [0:1];
  logic [NODE_W-1:0] fifo_data_d [0:1];
  logic              fifo_last_q [0:1];
  logic              fifo_last_d [0:1];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  // Output register
  logic              out_valid_q, out_valid_d;
  logic [NODE_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic              in_active;
  logic              ret_last;
  logic [ENG_W-1:0]  fetch_eng_inc;
  logic [ENG_W-1:0]  send_eng_inc;
  logic              last_arriving;
  logic [1:0]        occupancy;
  logic              issue;
  logic              transfer;
  logic              final_seg;
  logic              load_window;
  logic              out_free;
  logic              head_valid;
  logic [NODE_W-1:0] head_data;
  logic              head_last;
  logic              take;
  logic              pop;
  logic              push;

  always_comb begin
    in_active     = (state_q == ST_RUN) || (state_q == ST_SWITCH);
    ret_last      = mem_rdata[NODE_W];
    fetch_eng_inc = fetch_eng_q + ENG_W'(1);
    send_eng_inc  = send_eng_q + ENG_W'(1);
    // The word returning now closes the final segment: a read issued in this
    // same cycle would fetch past the end, so it is suppressed here.
    last_arriving = rvalid_q && ret_last && (fetch_eng_inc == num_eng_q);
    occupancy     = count_q + {1'b0, rvalid_q};
    issue         = (state_q == ST_RUN) && !conflict && (occupancy < 2'd2) &&
                    (fetch_eng_q != num_eng_q) && !last_arriving;

    transfer      = out_valid_q && !halt;
    final_seg     = (send_eng_inc == num_eng_q);
    // The register may prefill during SWITCH so the next segment's first
    // node appears right after the bubble.
    load_window   = (state_q == ST_RUN) || ((state_q == ST_SWITCH) && !final_seg);
    // A transferring last beat is not replaced: the following cycle is the
    // SWITCH bubble, which must show node_in_valid=0.
    out_free      = !out_valid_q || (transfer && !out_last_q);
    // A word returning while the FIFO is empty bypasses straight into the
    // output register, giving start-to-valid latency of three cycles.
    head_valid    = (count_q != 2'd0) || rvalid_q;
    head_data     = (count_q != 2'd0) ? fifo_data_q[rd_ptr_q] : mem_rdata[NODE_W-1:0];
    head_last     = (count_q != 2'd0) ? fifo_last_q[rd_ptr_q] : ret_last;
    take          = load_window && out_free && head_valid;
    pop           = take && (count_q != 2'd0);
    push          = rvalid_q && !(take && (count_q == 2'd0));
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    num_eng_d   = num_eng_q;
    fetch_eng_d = fetch_eng_q;
    send_eng_d  = send_eng_q;
    rvalid_d    = issue;
    aborted_d   = aborted_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (issue) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (in_active && !conflict) begin
      if (rvalid_q && ret_last) begin
        fetch_eng_d = fetch_eng_inc;
      end
      if (push) begin
        fifo_data_d[wr_ptr_q] = mem_rdata[NODE_W-1:0];
        fifo_last_d[wr_ptr_q] = ret_last;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (take) begin
        out_valid_d = 1'b1;
        out_data_d  = head_data;
        out_last_d  = head_last;
      end else if (transfer) begin
        out_valid_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          num_eng_d   = num_eng;
          fetch_eng_d = '0;
          send_eng_d  = '0;
          aborted_d   = 1'b0;
          count_d     = '0;
          wr_ptr_d    = 1'b0;
          rd_ptr_d    = 1'b0;
          out_valid_d = 1'b0;
          state_d     = (num_eng == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (transfer && out_last_q) begin
          state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        send_eng_d = send_eng_inc;
        state_d    = final_seg ? ST_DONE : ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort: flush everything buffered and drop the return in flight.
    if (in_active && conflict) begin
      aborted_d   = 1'b1;
      count_d     = '0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      out_valid_d = 1'b0;
      rvalid_d    = 1'b0;
      send_eng_d  = send_eng_q;
      state_d     = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      num_eng_q   <= '0;
      fetch_eng_q <= '0;
      send_eng_q  <= '0;
      rvalid_q    <= 1'b0;
      aborted_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      num_eng_q   <= num_eng_d;
      fetch_eng_q <= fetch_eng_d;
      send_eng_q  <= send_eng_d;
      rvalid_q    <= rvalid_d;
      aborted_q   <= aborted_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef LOOKUP_FEEDER_PERF_EN
  logic [31:0] perf_nodes_q, perf_nodes_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_nodes_d  = perf_nodes_q;
    perf_stalls_d = perf_stalls_q;
    if ((state_q == ST_IDLE) && start) begin
      perf_nodes_d  = '0;
      perf_stalls_d = '0;
    end else begin
      if (transfer && (perf_nodes_q != 32'hFFFF_FFFF)) begin
        perf_nodes_d = perf_nodes_q + 32'd1;
      end
      if (out_valid_q && halt && (perf_stalls_q != 32'hFFFF_FFFF)) begin
        perf_stalls_d = perf_stalls_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_nodes_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_nodes_q  <= perf_nodes_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_nodes  = perf_nodes_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_nodes  = 32'd0;
  assign perf_stalls = 32'd0;
`endif

  assign mem_rd_en     = issue;
  assign mem_addr      = addr_q;
  assign node_in       = out_data_q;
  assign node_in_valid = out_valid_q;
  // Suppressed when an abort lands on the SWITCH cycle.
  assign change_eng    = (state_q == ST_SWITCH) && !conflict;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign aborted       = aborted_q;

endmodule
